// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: forwarding-select encoding and hazard FSM states.
// Combinational helpers only; no latency, no backpressure.
// Reserved select 2'b11 is treated as register-file.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN,
    DWAIT,
    HALT
  } hu_state_t;

  function automatic logic isExmemSel(input logic [1:0] sel);
    return sel == FWD_EXMEM;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// One cycle from inc to updated count; holds at all-ones, never wraps.
// No backpressure.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: latch enables/flushes and PC enable for a 5-stage core.
// Outputs are combinational from state and inputs; state and counters update next edge.
// Stalls the whole pipe while a dcache access is outstanding; HALT is sticky until reset.
module hazard_unit
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [1:0]       forwardA,
  input  logic [1:0]       forwardB,
  input  logic [1:0]       forwarddmemstore,
  input  logic             exmem_memread,
  input  logic             dmem_req,
  input  logic             dhit,
  input  logic             ihit,
  input  logic             branch_taken,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hu_state_t state;
  logic      flushPend;
  logic      loadUse;
  logic      memWait;
  logic      branchFlush;
  logic      active;

  assign loadUse = exmem_memread & (isExmemSel(forwardA) | isExmemSel(forwardB) |
                                    isExmemSel(forwarddmemstore));
  assign active  = (state != HALT);
  // In DWAIT the access is already known pending, so only dhit ends the wait.
  assign memWait = (state == DWAIT) ? ~dhit : (dmem_req & ~dhit);
  assign branchFlush = active & ~memWait & (branch_taken | flushPend);
  assign halted = (state == HALT);

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (!active || memWait) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (branchFlush) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (loadUse) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_flush = 1'b1;
    end else if (!ihit) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= RUN;
      flushPend <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (wb_halt) begin
            state <= HALT;
          end else if (memWait) begin
            state     <= DWAIT;
            flushPend <= branch_taken;
          end
        end
        DWAIT: begin
          if (wb_halt) begin
            state <= HALT;
          end else if (dhit) begin
            state     <= RUN;
            flushPend <= 1'b0;
          end else begin
            flushPend <= flushPend | branch_taken;
          end
        end
        default: state <= HALT;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) uStallCnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (active & ~pc_en),
    .clr   (1'b0),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) uFlushCnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (branchFlush),
    .clr   (1'b0),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: vector table plus multi-cycle corner sequences.
// Expected output words are queued when stimulus is driven and popped at the sampling edge.
module tb_hazard_unit;

  localparam int CNT_W = 32;

  logic             CLK = 1'b0;
  logic             nRST;
  logic [1:0]       forwardA, forwardB, forwarddmemstore;
  logic             exmem_memread, dmem_req, dhit, ihit, branch_taken, wb_halt;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, exmem_flush, halted;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks   = 0;
  int failures = 0;
  logic [8:0] expQ[$];

  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush, halted}
  localparam logic [8:0] O_RUN   = 9'b11111_000_0;
  localparam logic [8:0] O_LU    = 9'b00011_001_0;
  localparam logic [8:0] O_WAIT  = 9'b00000_000_0;
  localparam logic [8:0] O_BR    = 9'b11111_111_0;
  localparam logic [8:0] O_IMISS = 9'b01111_100_0;
  localparam logic [8:0] O_HALT  = 9'b00000_000_1;

  typedef struct packed {
    logic [1:0] fA, fB, fS;
    logic       mr, dr, dh, ih, br, wh;
    logic [8:0] exp;
  } vec_t;

  hazard_unit #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .forwardA(forwardA), .forwardB(forwardB), .forwarddmemstore(forwarddmemstore),
    .exmem_memread(exmem_memread), .dmem_req(dmem_req), .dhit(dhit), .ihit(ihit),
    .branch_taken(branch_taken), .wb_halt(wb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  function automatic logic [8:0] outWord();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
            ifid_flush, idex_flush, exmem_flush, halted};
  endfunction

  task automatic setIn(input logic [1:0] fA, input logic [1:0] fB, input logic [1:0] fS,
                       input logic mr, input logic dr, input logic dh, input logic ih,
                       input logic br, input logic wh);
    forwardA = fA; forwardB = fB; forwarddmemstore = fS;
    exmem_memread = mr; dmem_req = dr; dhit = dh; ihit = ih;
    branch_taken = br; wb_halt = wh;
  endtask

  task automatic checkOut(input string name);
    logic [8:0] e;
    logic [8:0] got;
    if (expQ.size() == 0) begin
      failures++;
      checks++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e   = expQ.pop_front();
      got = outWord();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL %s: got %b expected %b", name, got, e);
      end
    end
  endtask

  task automatic checkCnt(input string name, input logic [CNT_W-1:0] got,
                          input logic [CNT_W-1:0] e);
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, e);
    end
  endtask

  // Inputs are already driven (just after posedge); sample at negedge, then advance.
  task automatic step(input logic [8:0] e, input string name);
    expQ.push_back(e);
    @(negedge CLK);
    checkOut(name);
    @(posedge CLK);
    #1;
  endtask

  task automatic doReset();
    nRST = 1'b0;
    setIn(2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0);
    #1;
    expQ.push_back(O_RUN);
    checkOut("reset_outputs");
    checkCnt("reset_stall_cnt", stall_cnt, '0);
    checkCnt("reset_flush_cnt", flush_cnt, '0);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{fA:2'b00, fB:2'b00, fS:2'b00, mr:0, dr:0, dh:0, ih:1, br:0, wh:0, exp:O_RUN};
    vecs[1] = '{fA:2'b00, fB:2'b01, fS:2'b00, mr:1, dr:1, dh:1, ih:1, br:0, wh:0, exp:O_LU};
    vecs[2] = '{fA:2'b00, fB:2'b10, fS:2'b00, mr:1, dr:0, dh:0, ih:1, br:0, wh:0, exp:O_RUN};
    vecs[3] = '{fA:2'b11, fB:2'b11, fS:2'b11, mr:1, dr:0, dh:0, ih:1, br:0, wh:0, exp:O_RUN};
    vecs[4] = '{fA:2'b01, fB:2'b00, fS:2'b00, mr:1, dr:0, dh:0, ih:1, br:0, wh:0, exp:O_LU};
    vecs[5] = '{fA:2'b00, fB:2'b00, fS:2'b01, mr:0, dr:0, dh:0, ih:1, br:0, wh:0, exp:O_RUN};
    vecs[6] = '{fA:2'b00, fB:2'b00, fS:2'b00, mr:0, dr:0, dh:0, ih:0, br:0, wh:0, exp:O_IMISS};
    vecs[7] = '{fA:2'b01, fB:2'b00, fS:2'b00, mr:1, dr:1, dh:1, ih:1, br:1, wh:0, exp:O_BR};
    vecs[8] = '{fA:2'b00, fB:2'b00, fS:2'b00, mr:0, dr:0, dh:0, ih:0, br:1, wh:0, exp:O_BR};
    vecs[9] = '{fA:2'b00, fB:2'b00, fS:2'b01, mr:1, dr:0, dh:0, ih:0, br:0, wh:0, exp:O_LU};

    doReset();

    // Table: single-cycle RUN decisions (none enters DWAIT or HALT).
    for (int i = 0; i < 10; i++) begin
      setIn(vecs[i].fA, vecs[i].fB, vecs[i].fS, vecs[i].mr, vecs[i].dr,
            vecs[i].dh, vecs[i].ih, vecs[i].br, vecs[i].wh);
      step(vecs[i].exp, $sformatf("vec%0d", i));
    end
    checkCnt("table_stall_cnt", stall_cnt, 4);
    checkCnt("table_flush_cnt", flush_cnt, 2);

    // Mid-run reset clears counters asynchronously.
    setIn(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    step(O_IMISS, "pre_reset_imiss");
    doReset();

    // dcache miss: three wait cycles, then hit.
    for (int i = 0; i < 3; i++) begin
      setIn(2'b00, 2'b00, 2'b00, 0, 1, 0, 1, 0, 0);
      step(O_WAIT, $sformatf("miss_wait%0d", i));
    end
    setIn(2'b00, 2'b00, 2'b00, 0, 1, 1, 1, 0, 0);
    step(O_RUN, "miss_hit");
    checkCnt("miss_stall_cnt", stall_cnt, 3);
    setIn(2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0);
    step(O_RUN, "miss_after_run");

    // Branch seen during a miss is deferred until the hit cycle.
    setIn(2'b00, 2'b00, 2'b00, 0, 1, 0, 1, 1, 0);
    step(O_WAIT, "brmiss_c0");
    setIn(2'b00, 2'b00, 2'b00, 0, 1, 0, 1, 0, 0);
    step(O_WAIT, "brmiss_c1");
    setIn(2'b00, 2'b00, 2'b00, 0, 1, 1, 1, 0, 0);
    step(O_BR, "brmiss_hit");
    checkCnt("brmiss_flush_cnt", flush_cnt, 1);
    checkCnt("brmiss_stall_cnt", stall_cnt, 5);
    setIn(2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0);
    step(O_RUN, "brmiss_pend_cleared");

    // Reset inside DWAIT drops the pending flush.
    setIn(2'b00, 2'b00, 2'b00, 0, 1, 0, 1, 1, 0);
    step(O_WAIT, "dwait_enter");
    doReset();
    setIn(2'b00, 2'b00, 2'b00, 0, 1, 1, 1, 0, 0);
    step(O_RUN, "dwait_reset_no_flush");
    checkCnt("dwait_reset_flush_cnt", flush_cnt, 0);

    // Sticky halt: outputs and counters frozen regardless of inputs.
    setIn(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    step(O_IMISS, "halt_pre_imiss");
    setIn(2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 1);
    step(O_RUN, "halt_pulse");
    for (int i = 0; i < 4; i++) begin
      setIn(2'b00, 2'b00, 2'b00, 1'(i % 2), 1, 1'(i % 2), 1'(i % 2), 1'(i / 2), 0);
      step(O_HALT, $sformatf("halt_hold%0d", i));
    end
    checkCnt("halt_stall_frozen", stall_cnt, 1);
    checkCnt("halt_flush_frozen", flush_cnt, 0);
    doReset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
